spi_mode0_master: RTL and testbench
===================================

Name: spi_mode0_master

Overview:
- Byte-level SPI mode 0 master (CPOL=0, CPHA=0), MSB first.
- Sits directly downstream of the joystick transfer controller, which drives getByte/sndData and consumes BUSY/RxData.
- Drives SCLK/MOSI to the PmodJSTK and samples MISO.
- Exchanges one full-duplex byte per getByte request; the controller handles slave select.

Parameters:
- CLK_DIV, 1, CLK cycles per SCLK half-period (≥1); counter width = $clog2(CLK_DIV+1).
- GAP_CYCLES, 10, extra BUSY-high cycles after each byte; used only with SPI_BYTE_GAP_EN (≥1).

Ports:
- CLK  input  1  system clock; all logic on rising edge.
- RST  input  1  synchronous, active-high reset.
- getByte  input  1  transfer request; sampled only in Idle.
- sndData  input  8  byte to transmit; captured on the accepting cycle.
- MISO  input  1  serial data from slave.
- BUSY  output  1  high while a transfer (and optional gap) is in progress.
- RxData  output  8  last complete received byte; held until the next byte completes.
- MOSI  output  1  serial data to slave.
- SCLK  output  1  serial clock, idle low.

Behaviour:
- All outputs are registers. Reset values: BUSY=0, RxData=8'h00, MOSI=0, SCLK=0; state=Idle; shift registers, bit and divider counters = 0.
- RST is synchronous and overrides everything, including mid-transfer. The next edge forces reset values and no partial RxData update occurs.
- States: Idle, Low, High, Gap (macro only), Done.
- Idle: SCLK=0, BUSY=0.
  - getByte=1 → load tx shift register with sndData, MOSI<=sndData[7], BUSY<=1, bit counter<=0, divider<=0, go to Low.
  - getByte=0 → stay in Idle, MOSI holds 0.
- Low: SCLK=0; MOSI stable. After CLK_DIV cycles: SCLK<=1, rx shift <= {rx[6:0], MISO} (sampled on the same edge SCLK rises), go to High.
- High: SCLK=1. After CLK_DIV cycles: SCLK<=0.
  - bit counter ≠ 7 → MOSI<=next tx bit, bit counter+1, go to Low.
  - bit counter = 7 → RxData<=assembled byte, MOSI<=0, go to Gap (macro) or Done.
- Done: BUSY<=0 and RxData valid on the same edge BUSY falls. One cycle only, then Idle. getByte is ignored in Done.
- Timing without macro:
  - getByte accepted at edge N → BUSY=1 from N+1.
  - BUSY=0 at N+1+16*CLK_DIV.
  - Minimum request-to-request spacing is 16*CLK_DIV+2 cycles.
- getByte asserted while BUSY=1 is ignored and not queued. getByte held high continuously starts a new byte at every Idle visit.
- sndData changes after acceptance do not affect the byte in flight.
- MISO is sampled exactly 8 times per byte, once per SCLK rising edge.

Optional Feature:
- Macro SPI_BYTE_GAP_EN.
- Defined:
  - After the 8th High phase, enter Gap: SCLK=0, MOSI=0, BUSY held 1 for GAP_CYCLES cycles, then Done.
  - RxData is updated on entry to Gap, before BUSY falls.
  - This meets the PmodJSTK inter-byte delay without help from the controller.
- Undefined: Gap state and its counter are not built; GAP_CYCLES is ignored; timing is as in Behaviour.

Test Plan:
- CLK_DIV=1, sndData=8'hA5, slave model returns 8'h3C:
  - MOSI bits at SCLK rises = 1,0,1,0,0,1,0,1.
  - Exactly 8 SCLK pulses, BUSY high exactly 16 cycles.
  - RxData=8'h3C when BUSY falls.
- CLK_DIV=3, sndData=8'h80, slave returns 8'h01: SCLK high/low each 3 cycles, BUSY high 48 cycles, RxData=8'h01.
- Pulse getByte again while BUSY=1 (mid-byte), sndData=8'hFF: ignored; in-flight byte, MOSI sequence and RxData unchanged.
- Assert RST when bit counter=4: next edge BUSY=0, SCLK=0, MOSI=0, RxData=8'h00; new getByte with 8'h5A completes normally.
- Five back-to-back bytes with getByte held high, slave returns 8'h11..8'h55: each RxData correct, one BUSY-low cycle between bytes, no extra SCLK edges.
- SPI_BYTE_GAP_EN, GAP_CYCLES=10, CLK_DIV=1: BUSY high 26 cycles, SCLK low for the final 10, RxData updated 10 cycles before BUSY falls.

Source files
------------

// File: rtl/spi_mode0_master_if.sv
// -----------------------------------------------------------------------------
// spi_mode0_master_if
//   Bundles the controller-side handshake and the SPI pins of the
//   byte-level SPI mode 0 master.
//
//   Signals:
//     getByte  transfer request (controller -> master)
//     sndData  byte to transmit (controller -> master)
//     BUSY     transfer in progress (master -> controller)
//     RxData   last complete received byte (master -> controller)
//     MISO     serial data from the slave device
//     MOSI     serial data to the slave device
//     SCLK     serial clock, idle low
//
//   Modports:
//     master   the SPI master block itself
//     slave    its environment (joystick controller plus the SPI device)
// -----------------------------------------------------------------------------
interface spi_mode0_master_if;
  logic       getByte;
  logic [7:0] sndData;
  logic       BUSY;
  logic [7:0] RxData;
  logic       MISO;
  logic       MOSI;
  logic       SCLK;

  modport master (
    input  getByte, sndData, MISO,
    output BUSY, RxData, MOSI, SCLK
  );

  modport slave (
    output getByte, sndData, MISO,
    input  BUSY, RxData, MOSI, SCLK
  );
endinterface

// File: rtl/spi_mode0_master.sv
// -----------------------------------------------------------------------------
// spi_mode0_master
//   Byte-level SPI mode 0 master (CPOL=0, CPHA=0), MSB first. Each accepted
//   getByte request exchanges one full-duplex byte with the PmodJSTK; slave
//   select is handled by the upstream joystick transfer controller.
//
//   Parameters:
//     CLK_DIV     CLK cycles per SCLK half-period (>= 1)
//     GAP_CYCLES  extra BUSY-high cycles after each byte (>= 1), only
//                 effective when SPI_BYTE_GAP_EN is defined
//
//   Optional feature macro: SPI_BYTE_GAP_EN
//     Defined   : after the 8th SCLK high phase a Gap state holds BUSY high
//                 for GAP_CYCLES cycles with SCLK and MOSI low, giving the
//                 PmodJSTK its inter-byte delay. RxData updates on Gap entry.
//     Undefined : no Gap state or counter; BUSY falls right after bit 7.
//
//   Ports:
//     CLK   system clock, all logic on the rising edge
//     RST   synchronous active-high reset, overrides everything
//     bus   spi_mode0_master_if.master (getByte, sndData, MISO in;
//           BUSY, RxData, MOSI, SCLK out - all outputs registered)
// -----------------------------------------------------------------------------
module spi_mode0_master #(
  parameter int CLK_DIV    = 1,
  parameter int GAP_CYCLES = 10
) (
  input  logic               CLK,
  input  logic               RST,
  spi_mode0_master_if.master bus
);

  localparam int               DIV_W    = $clog2(CLK_DIV + 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  // Both parameters are range-checked in every build so a bad GAP_CYCLES
  // is caught before the gap feature is ever switched on.
  if (CLK_DIV < 1) begin : gBadClkDiv
    $error("spi_mode0_master: CLK_DIV must be at least 1");
  end
  if (GAP_CYCLES < 1) begin : gBadGapCycles
    $error("spi_mode0_master: GAP_CYCLES must be at least 1");
  end

`ifdef SPI_BYTE_GAP_EN
  localparam int               GAP_W    = $clog2(GAP_CYCLES + 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES - 1);

  typedef enum logic [2:0] {
    StIdle = 3'd0,
    StLow  = 3'd1,
    StHigh = 3'd2,
    StDone = 3'd3,
    StGap  = 3'd4
  } state_t;
`else
  typedef enum logic [2:0] {
    StIdle = 3'd0,
    StLow  = 3'd1,
    StHigh = 3'd2,
    StDone = 3'd3
  } state_t;
`endif

  state_t           state_r,    stateNext_s;
  logic [6:0]       txRest_r,   txRestNext_s;   // bits still to be sent after the one on MOSI
  logic [7:0]       rxShift_r,  rxShiftNext_s;
  logic [2:0]       bitCnt_r,   bitCntNext_s;
  logic [DIV_W-1:0] divCnt_r,   divCntNext_s;
  logic             busy_r,     busyNext_s;
  logic [7:0]       rxData_r,   rxDataNext_s;
  logic             mosi_r,     mosiNext_s;
  logic             sclk_r,     sclkNext_s;
  logic             divEnd_s;
`ifdef SPI_BYTE_GAP_EN
  logic [GAP_W-1:0] gapCnt_r,   gapCntNext_s;
`endif

  // State and datapath registers; RST wins over any transfer in flight.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_r   <= StIdle;
      txRest_r  <= 7'h00;
      rxShift_r <= 8'h00;
      bitCnt_r  <= 3'd0;
      divCnt_r  <= '0;
      busy_r    <= 1'b0;
      rxData_r  <= 8'h00;
      mosi_r    <= 1'b0;
      sclk_r    <= 1'b0;
`ifdef SPI_BYTE_GAP_EN
      gapCnt_r  <= '0;
`endif
    end else begin
      state_r   <= stateNext_s;
      txRest_r  <= txRestNext_s;
      rxShift_r <= rxShiftNext_s;
      bitCnt_r  <= bitCntNext_s;
      divCnt_r  <= divCntNext_s;
      busy_r    <= busyNext_s;
      rxData_r  <= rxDataNext_s;
      mosi_r    <= mosiNext_s;
      sclk_r    <= sclkNext_s;
`ifdef SPI_BYTE_GAP_EN
      gapCnt_r  <= gapCntNext_s;
`endif
    end
  end

  // Next-state and next-output logic for the bit-level sequencer.
  always_comb begin
    stateNext_s   = state_r;
    txRestNext_s  = txRest_r;
    rxShiftNext_s = rxShift_r;
    bitCntNext_s  = bitCnt_r;
    divCntNext_s  = divCnt_r;
    busyNext_s    = busy_r;
    rxDataNext_s  = rxData_r;
    mosiNext_s    = mosi_r;
    sclkNext_s    = sclk_r;
`ifdef SPI_BYTE_GAP_EN
    gapCntNext_s  = gapCnt_r;
`endif
    divEnd_s      = (divCnt_r == DIV_LAST);

    case (state_r)
      StIdle: begin
        sclkNext_s = 1'b0;
        busyNext_s = 1'b0;
        if (bus.getByte) begin
          // MSB goes straight onto MOSI so it is stable for a full half-period
          // before the first rising SCLK edge.
          txRestNext_s = bus.sndData[6:0];
          mosiNext_s   = bus.sndData[7];
          busyNext_s   = 1'b1;
          bitCntNext_s = 3'd0;
          divCntNext_s = '0;
          stateNext_s  = StLow;
        end else begin
          mosiNext_s   = 1'b0;
        end
      end

      StLow: begin
        if (divEnd_s) begin
          // MISO is captured on the same CLK edge that raises SCLK.
          divCntNext_s  = '0;
          sclkNext_s    = 1'b1;
          rxShiftNext_s = {rxShift_r[6:0], bus.MISO};
          stateNext_s   = StHigh;
        end else begin
          divCntNext_s  = divCnt_r + DIV_W'(1'b1);
        end
      end

      StHigh: begin
        if (divEnd_s) begin
          divCntNext_s = '0;
          sclkNext_s   = 1'b0;
          if (bitCnt_r != 3'd7) begin
            mosiNext_s   = txRest_r[6];
            txRestNext_s = {txRest_r[5:0], 1'b0};
            bitCntNext_s = bitCnt_r + 3'd1;
            stateNext_s  = StLow;
          end else begin
            rxDataNext_s = rxShift_r;
            mosiNext_s   = 1'b0;
`ifdef SPI_BYTE_GAP_EN
            gapCntNext_s = '0;
            stateNext_s  = StGap;
`else
            busyNext_s   = 1'b0;
            stateNext_s  = StDone;
`endif
          end
        end else begin
          divCntNext_s = divCnt_r + DIV_W'(1'b1);
        end
      end

`ifdef SPI_BYTE_GAP_EN
      StGap: begin
        sclkNext_s = 1'b0;
        mosiNext_s = 1'b0;
        if (gapCnt_r == GAP_LAST) begin
          busyNext_s  = 1'b0;
          stateNext_s = StDone;
        end else begin
          gapCntNext_s = gapCnt_r + GAP_W'(1'b1);
        end
      end
`endif

      // One-cycle BUSY-low slot; a request here is deliberately ignored.
      StDone: begin
        busyNext_s  = 1'b0;
        sclkNext_s  = 1'b0;
        mosiNext_s  = 1'b0;
        stateNext_s = StIdle;
      end

      default: begin
        busyNext_s  = 1'b0;
        sclkNext_s  = 1'b0;
        mosiNext_s  = 1'b0;
        stateNext_s = StIdle;
      end
    endcase
  end

  assign bus.BUSY   = busy_r;
  assign bus.RxData = rxData_r;
  assign bus.MOSI   = mosi_r;
  assign bus.SCLK   = sclk_r;

endmodule

// File: tb/tb_spi_mode0_master.sv
// -----------------------------------------------------------------------------
// tb_spi_mode0_master
//   Directed bench for spi_mode0_master. Two instances share one clock:
//   dut1 with CLK_DIV=1 and dut3 with CLK_DIV=3. A simple mode 0 slave model
//   per instance serves MISO from a response byte, and monitors record MOSI
//   at each SCLK rise, count SCLK pulses, BUSY cycles and SCLK phase lengths.
//   Expected values track SPI_BYTE_GAP_EN when it is defined.
// -----------------------------------------------------------------------------
module tb_spi_mode0_master;

`ifdef SPI_BYTE_GAP_EN
  localparam int GAP = 10;
`else
  localparam int GAP = 0;
`endif
  localparam int EXP_BUSY1 = 16 + GAP;
  localparam int EXP_BUSY3 = 48 + GAP;

  logic clk = 1'b0;
  logic rst;

  int compared   = 0;
  int mismatched = 0;

  spi_mode0_master_if b1 ();
  spi_mode0_master_if b3 ();

  spi_mode0_master #(.CLK_DIV(1), .GAP_CYCLES(10)) dut1 (
    .CLK (clk),
    .RST (rst),
    .bus (b1)
  );

  spi_mode0_master #(.CLK_DIV(3), .GAP_CYCLES(10)) dut3 (
    .CLK (clk),
    .RST (rst),
    .bus (b3)
  );

  always #5 clk = ~clk;

  // ---------------- slave models and monitors ----------------
  int         rise1 = 0, rise3 = 0;
  int         base1 = 0, base3 = 0;
  logic [7:0] mosi1 = 8'h00, mosi3 = 8'h00;
  logic [7:0] resp1 = 8'h00, resp3 = 8'h00;
  logic       b2bMode = 1'b0;
  logic [7:0] b2bResp [0:7];
  int         busyCnt1 = 0, busyCnt3 = 0;
  int         hiRun3 = 0, loRun3 = 0, nHi3 = 0, badHi3 = 0, badLo3 = 0;

  int         k1, k3;
  logic [7:0] cur1;
  assign k1      = rise1 - base1;
  assign k3      = rise3 - base3;
  assign cur1    = b2bMode ? b2bResp[k1[5:3]] : resp1;
  assign b1.MISO = cur1[3'd7 - k1[2:0]];
  assign b3.MISO = resp3[3'd7 - k3[2:0]];

  // MOSI as seen by the slave at each SCLK rise, and pulse counts.
  always @(posedge b1.SCLK) begin
    rise1 <= rise1 + 1;
    mosi1 <= {mosi1[6:0], b1.MOSI};
  end

  always @(posedge b3.SCLK) begin
    rise3 <= rise3 + 1;
    mosi3 <= {mosi3[6:0], b3.MOSI};
  end

  // BUSY-high cycle counters (pre-edge values at every CLK edge).
  always @(posedge clk) begin
    if (b1.BUSY) busyCnt1 <= busyCnt1 + 1;
    if (b3.BUSY) busyCnt3 <= busyCnt3 + 1;
  end

  // SCLK phase length checker for dut3: every high and every in-byte low phase is 3 CLKs.
  always @(posedge clk) begin
    if (b3.SCLK) begin
      hiRun3 <= hiRun3 + 1;
      if (loRun3 != 0 && loRun3 != 3) badLo3 <= badLo3 + 1;
      loRun3 <= 0;
    end else begin
      hiRun3 <= 0;
      if (hiRun3 != 0) begin
        nHi3 <= nHi3 + 1;
        if (hiRun3 != 3) badHi3 <= badHi3 + 1;
      end
      loRun3 <= b3.BUSY ? loRun3 + 1 : 0;
    end
  end

  // ---------------- helpers ----------------
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic waitBusy(input bit onB3, input logic lvl, input int maxCyc, input string tag);
    int n;
    n = 0;
    while (((onB3 ? b3.BUSY : b1.BUSY) !== lvl) && (n < maxCyc)) begin
      @(negedge clk);
      n++;
    end
    chk(tag, onB3 ? b3.BUSY : b1.BUSY, lvl);
  endtask

  // One byte on dut1; pulseAt > 0 re-pulses getByte (with sndData=FF) mid-byte.
  task automatic runByte1(input string tag, input logic [7:0] d, input logic [7:0] r,
                          input int pulseAt);
    int n, early, b0;
    base1 = rise1;
    resp1 = r;
    b1.sndData = d;
    b1.getByte = 1'b1;
    b0 = busyCnt1;
    @(negedge clk);
    b1.getByte = 1'b0;
    chk({tag, "_busy_rise"}, b1.BUSY, 1'b1);
    n = 0;
    early = 0;
    while (b1.BUSY === 1'b1 && n < 400) begin
      if (b1.RxData === r) early++;
      if (pulseAt != 0 && n == pulseAt) begin
        b1.getByte = 1'b1;
        b1.sndData = 8'hFF;
      end else begin
        b1.getByte = 1'b0;
      end
      @(negedge clk);
      n++;
    end
    b1.getByte = 1'b0;
    chk({tag, "_busy_fall"}, b1.BUSY, 1'b0);
    chk({tag, "_rxdata"},    b1.RxData, r);
    chk({tag, "_mosi_bits"}, mosi1, d);
    chk({tag, "_sclk_rises"}, rise1 - base1, 8);
    chk({tag, "_busy_cycles"}, busyCnt1 - b0, EXP_BUSY1);
    chk({tag, "_rx_early"},  early, GAP);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int n, b0, h0;
    b2bResp[0] = 8'h11; b2bResp[1] = 8'h22; b2bResp[2] = 8'h33; b2bResp[3] = 8'h44;
    b2bResp[4] = 8'h55; b2bResp[5] = 8'h00; b2bResp[6] = 8'h00; b2bResp[7] = 8'h00;
    rst = 1'b1;
    b1.getByte = 1'b0; b1.sndData = 8'h00;
    b3.getByte = 1'b0; b3.sndData = 8'h00;
    repeat (3) @(negedge clk);

    // Reset values
    chk("rst_busy",   b1.BUSY,   1'b0);
    chk("rst_rxdata", b1.RxData, 8'h00);
    chk("rst_mosi",   b1.MOSI,   1'b0);
    chk("rst_sclk",   b1.SCLK,   1'b0);
    chk("rst_busy3",  b3.BUSY,   1'b0);
    rst = 1'b0;
    @(negedge clk);

    // A5 out, 3C in, CLK_DIV=1
    runByte1("a5", 8'hA5, 8'h3C, 0);
    repeat (2) @(negedge clk);

    // Mid-byte request with FF must be ignored and not queued
    runByte1("ignore", 8'hC3, 8'h96, 5);
    repeat (4) @(negedge clk);
    chk("ignore_not_queued", b1.BUSY, 1'b0);
    chk("ignore_no_sclk", rise1 - base1, 8);

    // Reset in the middle of bit 4
    base1 = rise1;
    resp1 = 8'h81;
    b1.sndData = 8'hE7;
    b1.getByte = 1'b1;
    @(negedge clk);
    b1.getByte = 1'b0;
    n = 0;
    while ((rise1 - base1) < 5 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("midrst_reach_bit4", rise1 - base1, 5);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_busy",   b1.BUSY,   1'b0);
    chk("midrst_sclk",   b1.SCLK,   1'b0);
    chk("midrst_mosi",   b1.MOSI,   1'b0);
    chk("midrst_rxdata", b1.RxData, 8'h00);
    rst = 1'b0;
    @(negedge clk);
    runByte1("recover", 8'h5A, 8'h3A, 0);
    repeat (2) @(negedge clk);

    // Five back-to-back bytes with getByte held high
    b2bMode = 1'b1;
    base1 = rise1;
    b1.sndData = 8'h0F;
    b1.getByte = 1'b1;
    for (int i = 0; i < 5; i++) begin
      waitBusy(1'b0, 1'b1, 40, $sformatf("b2b%0d_start", i));
      waitBusy(1'b0, 1'b0, 400, $sformatf("b2b%0d_end", i));
      if (i == 4) b1.getByte = 1'b0;
      chk($sformatf("b2b%0d_rxdata", i), b1.RxData, b2bResp[i]);
      chk($sformatf("b2b%0d_mosi", i), mosi1, 8'h0F);
      chk($sformatf("b2b%0d_rises", i), rise1 - base1, 8 * (i + 1));
      if (i < 4) begin
        n = 0;
        while (b1.BUSY !== 1'b1 && n < 10) begin
          @(negedge clk);
          n++;
        end
        // Done cycle plus the Idle cycle in which the request is accepted.
        chk($sformatf("b2b%0d_low_gap", i), n, 2);
      end
    end
    repeat (6) @(negedge clk);
    chk("b2b_stopped", b1.BUSY, 1'b0);
    chk("b2b_no_extra_sclk", rise1 - base1, 40);
    b2bMode = 1'b0;

    // 80 out, 01 in, CLK_DIV=3
    base3 = rise3;
    resp3 = 8'h01;
    b3.sndData = 8'h80;
    b3.getByte = 1'b1;
    b0 = busyCnt3;
    h0 = nHi3;
    @(negedge clk);
    b3.getByte = 1'b0;
    b3.sndData = 8'h7F;
    chk("div3_busy_rise", b3.BUSY, 1'b1);
    waitBusy(1'b1, 1'b0, 500, "div3_busy_fall");
    chk("div3_rxdata", b3.RxData, 8'h01);
    repeat (2) @(negedge clk);
    chk("div3_busy_cycles", busyCnt3 - b0, EXP_BUSY3);
    chk("div3_mosi_bits", mosi3, 8'h80);
    chk("div3_sclk_rises", rise3 - base3, 8);
    chk("div3_high_phases", nHi3 - h0, 8);
    chk("div3_bad_high_len", badHi3, 0);
    chk("div3_bad_low_len", badLo3, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  // Absolute time limit so the run always ends.
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

endmodule
